// File: rtl/image_ctrl.sv
// Image controller: tags a raster-order pixel stream with (m, n) coordinates, polices
// frame length against the DMA tlast and forwards beats through a two-entry skid buffer.
module image_ctrl #(
  parameter int unsigned I_DIM  = 8,
  parameter int unsigned M_BITS = 16,
  parameter int unsigned I_BITS = (I_DIM > 1) ? $clog2(I_DIM) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [M_BITS-1:0]      s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [M_BITS-1:0]      img_data,
  output logic [1:0][I_BITS-1:0] img_user,
  output logic                   img_last,
  output logic                   img_valid,
  input  logic                   img_ready,
  output logic                   frame_done,
  output logic                   frame_err,
  input  logic                   err_clr
);

  localparam int unsigned       TagW    = M_BITS + 2 * I_BITS + 1;
  localparam logic [I_BITS-1:0] LastIdx = I_BITS'(I_DIM - 1);
  localparam logic [0:0]        StStream = 1'b0;
  localparam logic [0:0]        StDrop   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [I_BITS-1:0] m_q, m_d;
  logic [I_BITS-1:0] n_q, n_d;
  logic [1:0]        count_q, count_d;
  logic [TagW-1:0]   ent0_q, ent0_d;
  logic [TagW-1:0]   ent1_q, ent1_d;
  logic              tready_q, tready_d;
  logic              frame_err_q, frame_err_d;
  logic              frame_done_q, frame_done_d;

  logic            in_hs, push, pop, gen_last, err_set;
  logic [TagW-1:0] new_tag;

  // Entry 0 is the head of the FIFO and drives the output directly.
  assign img_valid     = (count_q != 2'd0);
  assign img_data      = ent0_q[TagW-1 -: M_BITS];
  assign img_user      = ent0_q[2*I_BITS:1];
  assign img_last      = ent0_q[0];
  assign s_axis_tready = tready_q;
  assign frame_err     = frame_err_q;
  assign frame_done    = frame_done_q;

  always_comb begin
    state_d      = state_q;
    m_d          = m_q;
    n_d          = n_q;
    count_d      = count_q;
    ent0_d       = ent0_q;
    ent1_d       = ent1_q;
    err_set      = 1'b0;

    in_hs    = s_axis_tvalid && tready_q;
    push     = in_hs && (state_q == StStream);
    pop      = img_valid && img_ready;
    gen_last = (m_q == LastIdx) && (n_q == LastIdx);
    new_tag  = {s_axis_tdata, m_q, n_q, gen_last || s_axis_tlast};

    if (push) begin
      if (gen_last || s_axis_tlast) begin
        m_d     = '0;
        n_d     = '0;
        err_set = gen_last ^ s_axis_tlast;
        // Long frame: swallow everything up to the DMA's own tlast.
        if (gen_last && !s_axis_tlast) begin
          state_d = StDrop;
        end
      end else if (n_q == LastIdx) begin
        n_d = '0;
        m_d = m_q + 1'b1;
      end else begin
        n_d = n_q + 1'b1;
      end
    end else if (in_hs && s_axis_tlast) begin
      state_d = StStream;
      m_d     = '0;
      n_d     = '0;
    end

    if (push && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
      ent0_d = new_tag;
    end else if (push) begin
      ent1_d = new_tag;
    end else if (pop && (count_q == 2'd2)) begin
      ent0_d = ent1_q;
    end
    count_d = count_q + 2'(push) - 2'(pop);

    frame_err_d  = err_set ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
    frame_done_d = pop && img_last;
    tready_d     = (state_d == StDrop) || (count_d < 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StStream;
      m_q          <= '0;
      n_q          <= '0;
      count_q      <= '0;
      ent0_q       <= '0;
      ent1_q       <= '0;
      tready_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_q          <= m_d;
      n_q          <= n_d;
      count_q      <= count_d;
      ent0_q       <= ent0_d;
      ent1_q       <= ent1_d;
      tready_q     <= tready_d;
      frame_err_q  <= frame_err_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_image_ctrl.sv
// Directed bench for image_ctrl: frame tagging, backpressure, short/long frames,
// mid-frame reset and frame_err clear priority.
module tb_image_ctrl;

  localparam int unsigned I_DIM  = 8;
  localparam int unsigned M_BITS = 16;
  localparam int unsigned I_BITS = 3;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [M_BITS-1:0] s_axis_tdata = '0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [M_BITS-1:0] img_data;
  logic [1:0][I_BITS-1:0] img_user;
  logic              img_last;
  logic              img_valid;
  logic              img_ready = 1'b0;
  logic              frame_done;
  logic              frame_err;
  logic              err_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [22:0] cap_q[$];
  int          fd_cnt;
  bit          saw_low;
  logic [15:0] lfsr = 16'hACE1;
  logic [15:0] base = 16'h0;

  image_ctrl #(.I_DIM(I_DIM), .M_BITS(M_BITS), .I_BITS(I_BITS)) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .img_data(img_data), .img_user(img_user), .img_last(img_last),
    .img_valid(img_valid), .img_ready(img_ready),
    .frame_done(frame_done), .frame_err(frame_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Streams nb beats (data = base + index, tlast on index last_at) and captures every
  // output handshake as {last, user, data}; checks output stability while stalled.
  task automatic send(input int nb, input int last_at, input bit rnd, input bit clr_last);
    int tx = 0;
    int cyc = 0;
    int quiet = 0;
    bit held = 1'b0;
    logic [23:0] hold_v = '0;
    logic [23:0] cur_v;
    cap_q.delete();
    fd_cnt  = 0;
    saw_low = 1'b0;
    while (quiet < 2 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (frame_done) fd_cnt++;
      cur_v = {img_valid, img_last, img_user, img_data};
      if (held) chk("stall_hold", 32'(cur_v), 32'(hold_v));
      img_ready = rnd ? ((cyc > 4) && lfsr[0]) : 1'b1;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (img_valid && img_ready) cap_q.push_back(cur_v[22:0]);
      held   = img_valid && !img_ready;
      hold_v = cur_v;
      s_axis_tvalid = (tx < nb);
      s_axis_tdata  = base + 16'(tx);
      s_axis_tlast  = (tx == last_at);
      if (!s_axis_tready) saw_low = 1'b1;
      err_clr = clr_last && s_axis_tvalid && s_axis_tready && s_axis_tlast;
      if (s_axis_tvalid && s_axis_tready) tx++;
      if (tx >= nb && !img_valid) quiet++;
      else quiet = 0;
    end
    chk("send_timeout", 32'(cyc < 2000), 32'd1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    err_clr       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({s_axis_tready, img_valid, img_data, img_user, img_last,
                              frame_done, frame_err}), 32'd0);
    rstn = 1'b1;
    img_ready = 1'b1;
    @(negedge clk);
    chk("tready_after_reset", 32'(s_axis_tready), 32'd1);

    // Full frame, img_ready=1: one-cycle latency, one beat per cycle
    for (int i = 0; i <= 64; i++) begin
      @(negedge clk);
      if (i > 0)
        chk("t1_beat", 32'({img_valid, img_last, img_user, img_data}),
            32'({1'b1, (i - 1) == 63, 6'(i - 1), 16'(16'h0100 + 16'(i - 1))}));
      if (i < 64) chk("t1_tready", 32'(s_axis_tready), 32'd1);
      s_axis_tvalid = (i < 64);
      s_axis_tdata  = 16'h0100 + 16'(i);
      s_axis_tlast  = (i == 63);
    end
    @(negedge clk);
    chk("t1_frame_done", 32'({frame_done, img_valid}), 32'b10);
    @(negedge clk);
    chk("t1_done_once", 32'(frame_done), 32'd0);
    chk("t1_no_err", 32'(frame_err), 32'd0);

    // Same frame with pseudo-random backpressure
    base = 16'h2000;
    send(64, 63, 1'b1, 1'b0);
    chk("t2_count", 32'(cap_q.size()), 32'd64);
    if (cap_q.size() == 64)
      for (int k = 0; k < 64; k++)
        chk("t2_beat", 32'(cap_q[k]), 32'({k == 63, 6'(k), 16'(base + 16'(k))}));
    chk("t2_tready_dropped", 32'(saw_low), 32'd1);
    chk("t2_frame_done", 32'(fd_cnt), 32'd1);
    chk("t2_no_err", 32'(frame_err), 32'd0);

    // Short frame: tlast on beat 10 -> coordinates (1,1), forced last
    base = 16'h3000;
    send(10, 9, 1'b0, 1'b0);
    chk("t3_count", 32'(cap_q.size()), 32'd10);
    if (cap_q.size() == 10) begin
      chk("t3_beat9", 32'(cap_q[9]), 32'({1'b1, 6'd9, 16'h3009}));
      chk("t3_beat8", 32'(cap_q[8]), 32'({1'b0, 6'd8, 16'h3008}));
    end
    chk("t3_err", 32'(frame_err), 32'd1);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    chk("t3_err_cleared", 32'(frame_err), 32'd0);

    // Long frame: 70 beats, only 64 forwarded, next frame restarts at (0,0)
    base = 16'h4000;
    send(70, 69, 1'b0, 1'b0);
    chk("t4_count", 32'(cap_q.size()), 32'd64);
    if (cap_q.size() == 64) begin
      chk("t4_first", 32'(cap_q[0]), 32'({1'b0, 6'd0, 16'h4000}));
      chk("t4_beat62", 32'(cap_q[62]), 32'({1'b0, 6'd62, 16'h403e}));
      chk("t4_beat63", 32'(cap_q[63]), 32'({1'b1, 6'd63, 16'h403f}));
    end
    chk("t4_frame_done", 32'(fd_cnt), 32'd1);
    chk("t4_err", 32'(frame_err), 32'd1);

    // Reset after 20 accepted beats with 2 buffered and img_ready=0
    base = 16'h5000;
    send(18, -1, 1'b0, 1'b0);
    if (cap_q.size() == 18) chk("t5_first", 32'(cap_q[0]), 32'({1'b0, 6'd0, 16'h5000}));
    else chk("t5_count", 32'(cap_q.size()), 32'd18);
    @(negedge clk);
    img_ready = 1'b0;
    chk("t5_tready_a", 32'(s_axis_tready), 32'd1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'h5012;
    @(negedge clk);
    chk("t5_tready_b", 32'(s_axis_tready), 32'd1);
    s_axis_tdata = 16'h5013;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    chk("t5_full", 32'({s_axis_tready, img_valid, img_user, img_data}),
        32'({1'b0, 1'b1, 6'd18, 16'h5012}));
    rstn = 1'b0;
    @(negedge clk);
    chk("t5_reset_outputs", 32'({s_axis_tready, img_valid, img_data, img_user, img_last,
                                 frame_done, frame_err}), 32'd0);
    rstn = 1'b1;
    img_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_stale_beat", 32'(img_valid), 32'd0);
    end

    base = 16'h6000;
    send(64, 63, 1'b0, 1'b0);
    chk("t5_next_count", 32'(cap_q.size()), 32'd64);
    if (cap_q.size() == 64) begin
      chk("t5_next_first", 32'(cap_q[0]), 32'({1'b0, 6'd0, 16'h6000}));
      chk("t5_next_last", 32'(cap_q[63]), 32'({1'b1, 6'd63, 16'h603f}));
    end
    chk("t5_next_no_err", 32'(frame_err), 32'd0);

    // err_clr colliding with a new short-frame error: error wins
    base = 16'h7000;
    send(3, 2, 1'b0, 1'b0);
    chk("t6_err_set", 32'(frame_err), 32'd1);
    send(3, 2, 1'b0, 1'b1);
    chk("t6_err_wins", 32'(frame_err), 32'd1);
    if (cap_q.size() == 3) chk("t6_restart", 32'(cap_q[0]), 32'({1'b0, 6'd0, 16'h7000}));
    else chk("t6_count", 32'(cap_q.size()), 32'd3);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    chk("t6_err_clr", 32'(frame_err), 32'd0);
    @(negedge clk);
    chk("t6_err_stays_clr", 32'(frame_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_ctrl.md
# image_ctrl

Image controller feeding the multiplier array. Accepts a raster-order pixel stream from the image DMA channel and tags each pixel with its (m, n) image coordinates. Generates the frame-last flag from its own counters and forwards each pixel over the img_* handshake into mult_block. It also polices frame length against the DMA tlast and buffers two beats so full throughput survives downstream backpressure.

## Interface
- I_DIM, 8, image cache dimension (pixels per row and per column)
- M_BITS, 16, floating-point pixel width
- I_SIZE, sq(I_DIM), pixels per frame
- I_BITS, nbits(I_DIM), coordinate field width (holds 0..I_DIM-1)

- clk  in  1  single clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- s_axis_tdata  in  M_BITS  pixel from DMA
- s_axis_tlast  in  1  DMA end-of-frame marker
- s_axis_tvalid  in  1  DMA beat valid
- s_axis_tready  out  1  accepting DMA beat
- img_data  out  M_BITS  pixel to multipliers
- img_user  out  [1:0][I_BITS]  [1]=m (row), [0]=n (column)
- img_last  out  1  pixel (I_DIM-1, I_DIM-1), or forced on short frame
- img_valid  out  1  output beat valid
- img_ready  in  1  multiplier array accepting
- frame_done  out  1  one-cycle pulse on output handshake of an img_last beat
- frame_err  out  1  sticky frame-length error
- err_clr  in  1  clears frame_err

## Operation
- Input handshake: s_axis_tvalid && s_axis_tready. Output handshake: img_valid && img_ready.
- Counters m, n start at (0,0). On each forwarded input beat:
  - n increments; at I_DIM-1 it wraps to 0 and m increments.
  - After (I_DIM-1, I_DIM-1) both counters return to (0,0).
- Tag = {tdata, m, n, gen_last}, where gen_last = (m==I_DIM-1 && n==I_DIM-1). The tag is captured at input acceptance and stored in the skid buffer.
- State STREAM (reset state), normal case: tlast coincides with gen_last. Beat is forwarded with img_last=1; counters go to (0,0).
- STREAM, short frame: tlast=1 and gen_last=0.
  - Beat is forwarded with img_last=1 and its true coordinates.
  - frame_err is set; counters go to (0,0); state stays STREAM.
- STREAM, long frame: gen_last=1 and tlast=0.
  - Beat is forwarded with img_last=1; frame_err is set; next state DROP.
- DROP:
  - s_axis_tready=1 regardless of buffer state; beats are consumed and not forwarded.
  - The beat with tlast=1 returns to STREAM with counters at (0,0).
- frame_err: set by either error and held until err_clr=1. If err_clr and a new error occur in the same cycle, the error wins (frame_err=1).
- Skid buffer: 2 entries, FIFO order. s_axis_tready = (count<2) in STREAM.

## Timing
- Reset (rstn=0 at clock edge) forces:
  - s_axis_tready=0, img_valid=0, img_data=0, img_user=0, img_last=0, frame_done=0, frame_err=0
  - buffer empty, counters (0,0), state STREAM
- s_axis_tready=1 from the first cycle after rstn returns high.
- Reset mid-frame discards buffered beats and the partial count. No beat is emitted after the reset edge.
- Latency: a beat accepted in cycle t appears on img_* in cycle t+1 (registered output) if the buffer was empty.
- Throughput: 1 beat/cycle while img_ready=1; no bubbles at frame boundaries.
- While img_valid=1 and img_ready=0, img_data, img_user and img_last are held stable. img_valid does not drop until the handshake completes.
- s_axis_tready is registered; it deasserts in the cycle after the second beat is buffered without output drain.
- Simultaneous input and output handshake with count=2 is not possible, since tready=0. With count=1, count stays 1.
- frame_done is asserted in the cycle after the img_last output handshake, for exactly one cycle.

## Test plan
- I_DIM=8, 64 contiguous beats with tlast on the 64th, img_ready=1:
  - img_user runs (0,0),(0,1)…(7,7), one beat per cycle, 1-cycle latency.
  - img_last only on (7,7); frame_done pulses once; frame_err=0.
- Same frame with img_ready toggling in a pseudo-random pattern:
  - All 64 pixels arrive in order, with no loss and no duplication; outputs stay stable while stalled.
  - s_axis_tready drops after 2 beats are buffered.
- Short frame, tlast on beat 10:
  - Beat 10 is emitted with img_user=(1,1) and img_last=1; frame_err=1.
  - The next beat is tagged (0,0).
- Long frame, 70 beats with tlast on the 70th:
  - 64 beats are forwarded, the 64th with img_last=1; beats 65–70 are accepted and dropped; frame_err=1.
  - The following frame starts at (0,0).
- Reset after 20 accepted beats, with 2 buffered and img_ready=0:
  - All outputs are 0 in the next cycle; buffered beats are never emitted.
  - The next frame starts at (0,0).
- frame_err=1, then err_clr=1 in the same cycle as a new short-frame tlast: frame_err stays 1. A later err_clr alone clears it to 0.
